// File: rtl/inst_loader.sv
// Instruction-memory loader: streams words into the CPU's RAM while holding it in
// reset, re-reads the image to compare rotate-XOR checksums, then releases the CPU.
module inst_loader #(
    parameter int ADDR_W   = 6,
    parameter int HOLD_CYC = 4
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       csum
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam int HW = (HOLD_CYC < 2) ? 1 : $clog2(HOLD_CYC);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_VERIFY, S_HOLD, S_RUN, S_FAIL
    } state_t;

    function automatic logic [31:0] fold(input logic [31:0] s, input logic [31:0] w);
        return {s[30:0], s[31]} ^ w;
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [31:0]       csum_q, csum_d;
    logic [31:0]       vsum_q, vsum_d;
    logic              err_q, err_d;
    logic              in_ready_q, in_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_din_q, mem_din_d;
    logic [HW-1:0]     hold_q, hold_d;
    // vld_pipe_q[0]: read address issued last edge; [1]: RAM data valid this cycle
    logic [1:0]        vld_pipe_q, vld_pipe_d;

    logic idle_like, can_start, len_ok, xfer, last_xfer, issue, vdone, match, hold_end;
    logic [31:0] vsum_fold;

    always_comb begin
        idle_like = (state_q == S_IDLE) || (state_q == S_RUN) || (state_q == S_FAIL);
        can_start = idle_like && start;
        len_ok    = (len != '0) && (len <= DEPTH);
        xfer      = (state_q == S_LOAD) && in_valid && in_ready_q;
        last_xfer = xfer && (idx_q == n_q - 1'b1);
        issue     = (state_q == S_VERIFY) && (idx_q != n_q);
        vsum_fold = fold(vsum_q, mem_dout);
        vdone     = (state_q == S_VERIFY) && vld_pipe_q[1] && !vld_pipe_q[0];
        match     = (vsum_fold == csum_q);
        hold_end  = (state_q == S_HOLD) && (hold_q == HOLD_LAST);
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            idx_q      <= '0;
            csum_q     <= '0;
            vsum_q     <= '0;
            err_q      <= 1'b0;
            in_ready_q <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            hold_q     <= '0;
            vld_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            csum_q     <= csum_d;
            vsum_q     <= vsum_d;
            err_q      <= err_d;
            in_ready_q <= in_ready_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            hold_q     <= hold_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_RUN, S_FAIL: if (can_start && len_ok) state_d = S_LOAD;
            S_LOAD:                if (last_xfer) state_d = S_VERIFY;
            S_VERIFY:              if (vdone) state_d = match ? S_HOLD : S_FAIL;
            S_HOLD:                if (hold_end) state_d = S_RUN;
            default:               state_d = S_IDLE;
        endcase
    end

    always_comb begin
        n_d        = n_q;
        idx_d      = idx_q;
        csum_d     = csum_q;
        vsum_d     = vsum_q;
        err_d      = err_q;
        in_ready_d = in_ready_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        hold_d     = (state_q == S_HOLD) ? hold_q + 1'b1 : '0;
        vld_pipe_d = {vld_pipe_q[0], issue};

        if (can_start) begin
            if (len_ok) begin
                n_d        = len;
                err_d      = 1'b0;
                csum_d     = '0;
                vsum_d     = '0;
                idx_d      = '0;
                in_ready_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        if (xfer) begin
            mem_we_d   = 1'b1;
            mem_addr_d = idx_q[ADDR_W-1:0];
            mem_din_d  = in_data;
            csum_d     = fold(csum_q, in_data);
            idx_d      = last_xfer ? '0 : idx_q + 1'b1;
            if (last_xfer) in_ready_d = 1'b0;
        end

        if (issue) begin
            mem_addr_d = idx_q[ADDR_W-1:0];
            idx_d      = idx_q + 1'b1;
        end

        if ((state_q == S_VERIFY) && vld_pipe_q[1]) vsum_d = vsum_fold;
        if (vdone && !match) err_d = 1'b1;
    end

    always_comb begin
        cpu_rst = 1'b1;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_LOAD, S_VERIFY, S_HOLD: busy = 1'b1;
            S_RUN: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
            end
            default: ;
        endcase
    end

    assign in_ready = in_ready_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign err      = err_q;
    assign csum     = csum_q;

endmodule
